// File: rtl/axi_modport_pkg.sv
// Shared types and helpers for the axi_modport slave memory.
package axi_modport_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] MAX_SIZE    = 3'd2;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

   // A request is refused when its burst type, size or WRAP geometry is unsupported.
   function automatic logic req_error(input logic [1:0]  burst,
                                      input logic [2:0]  size,
                                      input logic [3:0]  len,
                                      input logic [31:0] addr);
      logic [31:0] step_mask;
      step_mask = (32'd1 << size) - 32'd1;
      return (burst == BURST_RSVD) || (size > MAX_SIZE) ||
             ((burst == BURST_WRAP) &&
              (!wrap_len_ok(len) || ((addr & step_mask) != 32'd0)));
   endfunction

endpackage

// File: rtl/axi_modport_addr_gen.sv
// Next-beat address for FIXED, INCR and WRAP bursts.
module axi_modport_addr_gen
   import axi_modport_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic [3:0]  len,
   input  logic [1:0]  burst,
   output logic [31:0] next_addr
);

   logic [31:0] step_s;
   logic [31:0] span_s;

   // Step by the transfer size; WRAP folds back inside a (len+1)*step window.
   always_comb begin
      step_s    = 32'd1 << size;
      span_s    = ({28'd0, len} + 32'd1) << size;
      next_addr = addr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = addr + step_s;
         BURST_WRAP:  next_addr = (addr & ~(span_s - 32'd1)) |
                                  ((addr + step_s) & (span_s - 32'd1));
         default:     next_addr = addr;
      endcase
   end

endmodule

// File: rtl/axi_modport.sv
// AXI3-style slave memory: independent write and read FSMs, one transaction each.
module axi_modport
   import axi_modport_pkg::*;
#(
   parameter int MEM_DEPTH = 1024
)
(
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [3:0]  AWID,
   input  logic [31:0] AWADDR,
   input  logic [3:0]  AWLEN,
   input  logic [2:0]  AWSIZE,
   input  logic [1:0]  AWBURST,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [3:0]  WID,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic [3:0]  BID,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   input  logic [3:0]  ARID,
   input  logic [31:0] ARADDR,
   input  logic [3:0]  ARLEN,
   input  logic [2:0]  ARSIZE,
   input  logic [1:0]  ARBURST,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [3:0]  RID,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   logic [31:0] mem [0:MEM_DEPTH-1];

   wr_state_e   w_state_r;
   logic [3:0]  w_id_r;
   logic [31:0] w_addr_r;
   logic [3:0]  w_len_r;
   logic [2:0]  w_size_r;
   logic [1:0]  w_burst_r;
   logic [3:0]  w_cnt_r;
   logic        w_err_r;
   logic        w_proto_r;
   logic [31:0] w_next_s;

   rd_state_e   r_state_r;
   logic [31:0] r_addr_r;
   logic [3:0]  r_len_r;
   logic [2:0]  r_size_r;
   logic [1:0]  r_burst_r;
   logic [3:0]  r_cnt_r;
   logic        r_err_r;
   logic [31:0] r_next_s;

   logic aw_fire_s;
   logic w_fire_s;
   logic w_last_s;
   logic beat_err_s;
   logic mem_we_s;
   logic aw_err_s;
   logic ar_fire_s;
   logic ar_err_s;

   assign aw_fire_s  = AWVALID & AWREADY;
   assign w_fire_s   = WVALID & WREADY;
   assign w_last_s   = (w_cnt_r == w_len_r);
   assign beat_err_s = (WID != w_id_r) | (WLAST != w_last_s);
   assign mem_we_s   = w_fire_s & ~w_err_r;
   assign aw_err_s   = req_error(AWBURST, AWSIZE, AWLEN, AWADDR);
   assign ar_fire_s  = ARVALID & ARREADY;
   assign ar_err_s   = req_error(ARBURST, ARSIZE, ARLEN, ARADDR);

   axi_modport_addr_gen u_wr_addr (
      .addr      (w_addr_r),
      .size      (w_size_r),
      .len       (w_len_r),
      .burst     (w_burst_r),
      .next_addr (w_next_s)
   );

   axi_modport_addr_gen u_rd_addr (
      .addr      (r_addr_r),
      .size      (r_size_r),
      .len       (r_len_r),
      .burst     (r_burst_r),
      .next_addr (r_next_s)
   );

   // Byte-lane write into the word at the current write address (memory is never reset).
   always_ff @(posedge ACLK) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (WSTRB[i]) begin
               mem[w_addr_r[IDX_W+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
            end
         end
      end
   end

   // Write FSM: address handshake, data beats, then a held response.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state_r <= W_IDLE;
         AWREADY   <= 1'b0;
         WREADY    <= 1'b0;
         BVALID    <= 1'b0;
         BID       <= 4'd0;
         BRESP     <= 2'b00;
         w_id_r    <= 4'd0;
         w_addr_r  <= 32'd0;
         w_len_r   <= 4'd0;
         w_size_r  <= 3'd0;
         w_burst_r <= 2'd0;
         w_cnt_r   <= 4'd0;
         w_err_r   <= 1'b0;
         w_proto_r <= 1'b0;
      end else begin
         case (w_state_r)
            W_IDLE: begin
               if (aw_fire_s) begin
                  w_id_r    <= AWID;
                  w_addr_r  <= AWADDR;
                  w_len_r   <= AWLEN;
                  w_size_r  <= AWSIZE;
                  w_burst_r <= AWBURST;
                  w_cnt_r   <= 4'd0;
                  w_err_r   <= aw_err_s;
                  w_proto_r <= 1'b0;
                  AWREADY   <= 1'b0;
                  WREADY    <= 1'b1;
                  w_state_r <= W_DATA;
               end else begin
                  AWREADY <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire_s) begin
                  w_addr_r <= w_next_s;
                  if (beat_err_s) begin
                     w_proto_r <= 1'b1;
                  end
                  if (w_last_s) begin
                     WREADY    <= 1'b0;
                     BVALID    <= 1'b1;
                     BID       <= w_id_r;
                     BRESP     <= (w_err_r | w_proto_r | beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                     w_state_r <= W_RESP;
                  end else begin
                     w_cnt_r <= w_cnt_r + 4'd1;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID    <= 1'b0;
                  AWREADY   <= 1'b1;
                  w_state_r <= W_IDLE;
               end
            end
            default: begin
               w_state_r <= W_IDLE;
               AWREADY   <= 1'b0;
               WREADY    <= 1'b0;
               BVALID    <= 1'b0;
            end
         endcase
      end
   end

   // Read FSM: address handshake, then registered beats held until RREADY.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state_r <= R_IDLE;
         ARREADY   <= 1'b0;
         RVALID    <= 1'b0;
         RLAST     <= 1'b0;
         RID       <= 4'd0;
         RDATA     <= 32'd0;
         RRESP     <= 2'b00;
         r_addr_r  <= 32'd0;
         r_len_r   <= 4'd0;
         r_size_r  <= 3'd0;
         r_burst_r <= 2'd0;
         r_cnt_r   <= 4'd0;
         r_err_r   <= 1'b0;
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (ar_fire_s) begin
                  r_addr_r  <= ARADDR;
                  r_len_r   <= ARLEN;
                  r_size_r  <= ARSIZE;
                  r_burst_r <= ARBURST;
                  r_cnt_r   <= 4'd0;
                  r_err_r   <= ar_err_s;
                  ARREADY   <= 1'b0;
                  RVALID    <= 1'b1;
                  RID       <= ARID;
                  RDATA     <= ar_err_s ? 32'd0 : mem[ARADDR[IDX_W+1:2]];
                  RRESP     <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
                  RLAST     <= (ARLEN == 4'd0);
                  r_state_r <= R_DATA;
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  if (RLAST) begin
                     RVALID    <= 1'b0;
                     RLAST     <= 1'b0;
                     ARREADY   <= 1'b1;
                     r_state_r <= R_IDLE;
                  end else begin
                     r_addr_r <= r_next_s;
                     r_cnt_r  <= r_cnt_r + 4'd1;
                     RDATA    <= r_err_r ? 32'd0 : mem[r_next_s[IDX_W+1:2]];
                     RLAST    <= ((r_cnt_r + 4'd1) == r_len_r);
                  end
               end
            end
            default: begin
               r_state_r <= R_IDLE;
               ARREADY   <= 1'b0;
               RVALID    <= 1'b0;
               RLAST     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_modport.sv
// Directed self-checking bench for axi_modport.
module tb_axi_modport;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [3:0]  AWID;
   logic [31:0] AWADDR;
   logic [3:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWVALID;
   logic        AWREADY;
   logic [3:0]  WID;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        WVALID;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   int total = 0;
   int bad   = 0;

   logic [31:0] d [16];
   logic [31:0] e [16];

   axi_modport dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Full write transaction, called and returning on a falling edge.
   task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                     input int bad_beat, input int bhold, input logic [1:0] exp_resp);
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      for (int n = 0; n < 50 && !AWREADY; n++) @(negedge ACLK);
      check("awready", AWREADY, 1'b1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         WID    = (b == bad_beat) ? (id ^ 4'd1) : id;
         WDATA  = d[b];
         WSTRB  = strb;
         WLAST  = (b == int'(len));
         WVALID = 1'b1;
         for (int n = 0; n < 50 && !WREADY; n++) @(negedge ACLK);
         check("wready", WREADY, 1'b1);
         @(negedge ACLK);
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      for (int n = 0; n < 50 && !BVALID; n++) @(negedge ACLK);
      check("bvalid", BVALID, 1'b1);
      for (int h = 0; h < bhold; h++) begin
         @(negedge ACLK);
         check("bvalid_hold", BVALID, 1'b1);
         check("bid_hold", BID, id);
         check("bresp_hold", BRESP, exp_resp);
      end
      check("bid", BID, id);
      check("bresp", BRESP, exp_resp);
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      check("bvalid_clr", BVALID, 1'b0);
   endtask

   // Full read transaction against expected words e[], with optional RREADY stall per beat.
   task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst,
                     input logic [1:0] exp_resp, input int hold);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      for (int n = 0; n < 50 && !ARREADY; n++) @(negedge ACLK);
      check("arready", ARREADY, 1'b1);
      @(negedge ACLK);
      ARVALID = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         for (int n = 0; n < 50 && !RVALID; n++) @(negedge ACLK);
         check("rvalid", RVALID, 1'b1);
         check("rdata", RDATA, e[b]);
         check("rresp", RRESP, exp_resp);
         check("rid", RID, id);
         check("rlast", RLAST, b == int'(len));
         if (hold > 0) begin
            repeat (hold) @(negedge ACLK);
            check("rdata_hold", RDATA, e[b]);
            check("rlast_hold", RLAST, b == int'(len));
         end
         RREADY = 1'b1;
         @(negedge ACLK);
         RREADY = 1'b0;
      end
      check("rvalid_clr", RVALID, 1'b0);
   endtask

   initial begin
      ARESETn = 1'b0;
      AWID = 4'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWSIZE = 3'd0; AWBURST = 2'd0; AWVALID = 1'b0;
      WID = 4'd0; WDATA = 32'd0; WSTRB = 4'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARID = 4'd0; ARADDR = 32'd0; ARLEN = 4'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0;
      RREADY = 1'b0;
      for (int i = 0; i < 16; i++) begin d[i] = 32'd0; e[i] = 32'd0; end

      // Reset state
      repeat (3) @(negedge ACLK);
      check("rst_awready", AWREADY, 1'b0);
      check("rst_arready", ARREADY, 1'b0);
      check("rst_wready", WREADY, 1'b0);
      check("rst_bvalid", BVALID, 1'b0);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_rlast", RLAST, 1'b0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_bresp", {BID, BRESP, RID, RRESP}, 12'd0);
      ARESETn = 1'b1;
      @(negedge ACLK);
      check("post_rst_awready", AWREADY, 1'b1);
      check("post_rst_arready", ARREADY, 1'b1);

      // INCR write 0x10, data 1..4, then read back
      d[0] = 32'd1; d[1] = 32'd2; d[2] = 32'd3; d[3] = 32'd4;
      wr(4'd5, 32'h10, 4'd3, 3'd2, 2'd1, 4'hF, -1, 0, 2'b00);
      e[0] = 32'd1; e[1] = 32'd2; e[2] = 32'd3; e[3] = 32'd4;
      rd(4'd9, 32'h10, 4'd3, 3'd2, 2'd1, 2'b00, 0);

      // WRAP write at 0x38: lands at 0x38,0x3C,0x30,0x34
      d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2; d[3] = 32'hA3;
      wr(4'd2, 32'h38, 4'd3, 3'd2, 2'd2, 4'hF, -1, 0, 2'b00);
      e[0] = 32'hA2; e[1] = 32'hA3; e[2] = 32'hA0; e[3] = 32'hA1;
      rd(4'd3, 32'h30, 4'd3, 3'd2, 2'd1, 2'b00, 0);
      e[0] = 32'hA0; e[1] = 32'hA1; e[2] = 32'hA2; e[3] = 32'hA3;
      rd(4'd4, 32'h38, 4'd3, 3'd2, 2'd2, 2'b00, 0);

      // Misaligned WRAP write is refused and leaves memory unchanged
      d[0] = 32'hDEAD0000; d[1] = 32'hDEAD0001; d[2] = 32'hDEAD0002; d[3] = 32'hDEAD0003;
      wr(4'd6, 32'h3A, 4'd3, 3'd2, 2'd2, 4'hF, -1, 0, 2'b10);
      e[0] = 32'hA2; e[1] = 32'hA3; e[2] = 32'hA0; e[3] = 32'hA1;
      rd(4'd7, 32'h30, 4'd3, 3'd2, 2'd1, 2'b00, 0);

      // Partial strobe merge
      d[0] = 32'hAABBCCDD;
      wr(4'd1, 32'h100, 4'd0, 3'd2, 2'd1, 4'hF, -1, 0, 2'b00);
      d[0] = 32'h11223344;
      wr(4'd1, 32'h100, 4'd0, 3'd2, 2'd1, 4'b0101, -1, 0, 2'b00);
      e[0] = 32'hAA22CC44;
      rd(4'd8, 32'h100, 4'd0, 3'd2, 2'd1, 2'b00, 0);

      // Reserved burst read: zero data, SLVERR, RLAST on second beat
      e[0] = 32'd0; e[1] = 32'd0;
      rd(4'd10, 32'h10, 4'd1, 3'd2, 2'd3, 2'b10, 0);

      // BREADY held low for 5 cycles, RREADY stalled per beat
      d[0] = 32'h12345678; d[1] = 32'h9ABCDEF0;
      wr(4'd3, 32'h200, 4'd1, 3'd2, 2'd1, 4'hF, -1, 5, 2'b00);
      e[0] = 32'h12345678; e[1] = 32'h9ABCDEF0;
      rd(4'd11, 32'h200, 4'd1, 3'd2, 2'd1, 2'b00, 2);

      // WID mismatch on a beat: SLVERR, but memory still written
      d[0] = 32'h0000CAFE; d[1] = 32'h0000BEEF;
      wr(4'd4, 32'h400, 4'd1, 3'd2, 2'd1, 4'hF, 1, 0, 2'b10);
      e[0] = 32'h0000CAFE; e[1] = 32'h0000BEEF;
      rd(4'd12, 32'h400, 4'd1, 3'd2, 2'd1, 2'b00, 0);

      // Reset asserted during beat 2 of a LEN=7 write
      AWID = 4'd7; AWADDR = 32'h300; AWLEN = 4'd7; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
      for (int n = 0; n < 50 && !AWREADY; n++) @(negedge ACLK);
      check("mid_awready", AWREADY, 1'b1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      WID = 4'd7; WDATA = 32'h55; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      @(negedge ACLK);
      WDATA = 32'h66;
      #2 ARESETn = 1'b0;
      #1;
      check("mid_rst_awready", AWREADY, 1'b0);
      check("mid_rst_wready", WREADY, 1'b0);
      check("mid_rst_bvalid", BVALID, 1'b0);
      check("mid_rst_arready", ARREADY, 1'b0);
      check("mid_rst_rvalid", RVALID, 1'b0);
      @(negedge ACLK);
      WVALID = 1'b0;
      ARESETn = 1'b1;
      @(negedge ACLK);
      check("mid_post_awready", AWREADY, 1'b1);
      check("mid_post_bvalid", BVALID, 1'b0);
      d[0] = 32'h77; d[1] = 32'h88;
      wr(4'd9, 32'h500, 4'd1, 3'd2, 2'd1, 4'hF, -1, 0, 2'b00);
      e[0] = 32'h77; e[1] = 32'h88;
      rd(4'd13, 32'h500, 4'd1, 3'd2, 2'd1, 2'b00, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_modport.md
# axi_modport

AXI3-style slave memory implementing the slave-side (S_DRV) behaviour of the team's 32-bit AXI interface. Write-address, write-data, write-response, read-address and read-data channels drive a byte-addressable word memory with FIXED, INCR and WRAP bursts. It is the reference responder behind the master driver/monitor environment. Write and read paths run independently, one outstanding transaction each.

## Interface
- MEM_DEPTH, 1024, number of 32-bit words; word index = addr[log2(MEM_DEPTH)+1:2], upper bits ignored (aliasing)
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  4/32/4/3/2/1  write address; AWREADY out 1
- WID/WDATA/WSTRB/WLAST/WVALID  in  4/32/4/1/1  write data; WREADY out 1
- BID/BRESP/BVALID  out  4/2/1  write response; BREADY in 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  4/32/4/3/2/1  read address; ARREADY out 1
- RID/RDATA/RRESP/RLAST/RVALID  out  4/32/2/1/1  read data; RREADY in 1

## Operation
- Write FSM: W_IDLE (AWREADY=1) -> AW handshake latches id/addr/len/size/burst -> W_DATA (WREADY=1) -> each WVALID&WREADY beat writes bytes where WSTRB[i]=1 into lane i of word at current address, then advances address -> after beat len+1 -> W_RESP (BVALID=1, BID=latched AWID) -> BVALID&BREADY -> W_IDLE.
- Read FSM: R_IDLE (ARREADY=1) -> AR handshake latches fields -> R_DATA (RVALID=1, RID=latched ARID, RDATA=mem word at current address, RLAST=1 on beat len+1) -> each RVALID&RREADY advances; after last beat -> R_IDLE.
- Address step bytes = 1<<size. FIXED(0): unchanged. INCR(1): addr+step, 32-bit wrap. WRAP(2): span=(len+1)*step; next = (addr & ~(span-1)) | ((addr+step) & (span-1)).
- Byte-lane placement is the master's job; write data lanes map directly to memory lanes; reads return the full word.
- Error = BURST==3, SIZE>2, WRAP with LEN not in {1,3,7,15}, or WRAP address not aligned to step. Error write: beats still accepted, memory untouched, BRESP=SLVERR(2'b10). Error read: all beats RDATA=0, RRESP=SLVERR. Otherwise OKAY(2'b00).
- Write burst also gets SLVERR if any beat's WID≠AWID or WLAST mismatches the beat count (memory still written); burst always ends at beat len+1.

## Timing
- Reset: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0; both FSMs to idle. Memory not reset.
- First cycle after ARESETn rises: AWREADY=ARREADY=1.
- Handshake completes on rising edge with VALID&READY both high; all outputs registered.
- First WREADY / RVALID the cycle after address handshake; one beat per cycle when partner holds VALID/READY high.
- BVALID the cycle after the last write beat; held with BID/BRESP stable until BREADY.
- RVALID/RDATA/RRESP/RLAST/RID held stable until RREADY.
- Simultaneous write beat and read beat to same word: RDATA presented that cycle is the pre-write value.
- Reset asserted mid-burst: transaction aborted immediately, no response.

## Structure
- Package axi_modport_pkg: burst enum (FIXED, INCR, WRAP, RSVD), RESP_OKAY/RESP_SLVERR constants, MAX_SIZE=2, legal WRAP length check function.
- Sub-module axi_modport_addr_gen: combinational next address from addr/size/len/burst, instantiated for write and read paths.

## Test plan
- INCR write AWADDR=0x10, LEN=3, SIZE=2, WSTRB=4'hF, data 1..4; read back same -> RDATA 1,2,3,4, RLAST on 4th, BRESP=RRESP=OKAY, BID/RID echo IDs.
- WRAP write ADDR=0x38, LEN=3, SIZE=2 -> words written at 0x38,0x3C,0x30,0x34; misaligned ADDR=0x3A -> SLVERR, memory unchanged.
- WSTRB=4'b0101 over word 0xAABBCCDD with data 0x11223344 -> read 0xAA22CC44.
- BURST=3 read, LEN=1 -> two beats RDATA=0, RRESP=SLVERR, RLAST on 2nd.
- BREADY low 5 cycles, RREADY toggling -> BVALID/BID/BRESP and RDATA stable until handshake.
- ARESETn low during beat 2 of LEN=7 write -> all VALID/READY 0; after release AWREADY=1, new burst completes OKAY.
